// File: rtl/tile_renderer.sv
// tile_renderer: two-stage pixel pipeline that maps VGA counters onto a 40-pixel
// tile grid and resolves layer priority per pixel. The layers, from highest to
// lowest, are the homeworld column, the player, the bullets, the enemy grid and
// the backdrop.
// The block owns the enemy-cell storage. That storage has a ready/valid write
// port and a clear FSM.
// Bullet state is double buffered. The shadow slots take writes; frame_start
// copies them into the active slots that are drawn.
// Optional feature macro: GRID_LINES_EN (draws dim grid lines on the backdrop).
module tile_renderer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BSIZE       = 40,
    parameter int GRID_COLS   = 16,
    parameter int GRID_ROWS   = 12,
    parameter int NUM_BULLETS = 3,
    parameter int COLOR_W     = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         horiz_count_i,
    input  logic [9:0]         vert_count_i,
    input  logic               frame_start_i,
    input  logic [3:0]         player_row_i,
    input  logic               enemy_wr_valid_i,
    output logic               enemy_wr_ready_o,
    input  logic [2:0]         enemy_wr_row_i,
    input  logic [2:0]         enemy_wr_col_i,
    input  logic [COLOR_W-1:0] enemy_wr_color_i,
    input  logic               enemy_clear_i,
    input  logic               bullet_wr_en_i,
    input  logic [2:0]         bullet_wr_idx_i,
    input  logic [3:0]         bullet_wr_x_i,
    input  logic [3:0]         bullet_wr_y_i,
    input  logic [COLOR_W-1:0] bullet_wr_color_i,
    output logic [3:0]         red_o,
    output logic [3:0]         green_o,
    output logic [3:0]         blue_o,
    output logic               pixel_valid_o
);
    localparam int ENEMY_ROWS = GRID_ROWS / 2;
    localparam int ENEMY_COLS = GRID_COLS / 2 - 2;
    localparam int NCELLS     = ENEMY_ROWS * ENEMY_COLS;
    localparam int IDX_W      = $clog2(NCELLS);

    localparam logic [COLOR_W-1:0] HOME_C   = COLOR_W'(12'h282);
    localparam logic [COLOR_W-1:0] PLAYER_C = COLOR_W'(12'hFFF);
    localparam logic [COLOR_W-1:0] GRID_C   = COLOR_W'(12'h222);

    typedef struct packed {
        logic [3:0]         x;
        logic [3:0]         y;
        logic [COLOR_W-1:0] color;   // 0 = slot inactive
    } bullet_t;

    typedef enum logic { IDLE, CLEAR } state_t;

    // ---------------- stage 1: tile coordinates ----------------
    logic [9:0] col_q, row_q;
    logic       vis_q;
`ifdef GRID_LINES_EN
    logic       line_q;
`endif

    // Register the tile column/row and the visibility flag for the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            vis_q  <= 1'b0;
`ifdef GRID_LINES_EN
            line_q <= 1'b0;
`endif
        end else begin
            col_q  <= horiz_count_i / 10'(BSIZE);
            row_q  <= vert_count_i / 10'(BSIZE);
            vis_q  <= (horiz_count_i < 10'(H_ACTIVE)) && (vert_count_i < 10'(V_ACTIVE));
`ifdef GRID_LINES_EN
            line_q <= ((horiz_count_i % 10'(BSIZE)) == 10'd0) ||
                      ((vert_count_i % 10'(BSIZE)) == 10'd0);
`endif
        end
    end

    // ---------------- enemy storage and clear FSM ----------------
    logic [COLOR_W-1:0] cell_q [NCELLS];
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               wr_fire, wr_inrange;
    logic [IDX_W-1:0]   wr_idx;

    // Writes are accepted only during blanking, when no clear is running or starting.
    assign enemy_wr_ready_o = !vis_q && (state_q == IDLE) && !enemy_clear_i;
    assign wr_fire          = enemy_wr_valid_i && enemy_wr_ready_o;
    // Out-of-range coordinates are still handshaken but must not alias another cell.
    assign wr_inrange       = (int'(enemy_wr_row_i) < ENEMY_ROWS) && (int'(enemy_wr_col_i) < ENEMY_COLS);
    assign wr_idx           = IDX_W'(int'(enemy_wr_row_i) * ENEMY_COLS + int'(enemy_wr_col_i));

    // Register the clear FSM state and the row-major sweep index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state: a clear pulse starts a one-cell-per-cycle sweep; pulses during the sweep are ignored.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            IDLE: begin
                if (enemy_clear_i) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                if (clr_idx_q == IDX_W'(NCELLS - 1)) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Update the cells: the clear sweep takes precedence, then any accepted in-range write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCELLS; i++) cell_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            cell_q[clr_idx_q] <= '0;
        end else if (wr_fire && wr_inrange) begin
            cell_q[wr_idx] <= enemy_wr_color_i;
        end
    end

    // ---------------- bullets: shadow and active banks ----------------
    bullet_t sh_q [NUM_BULLETS];
    bullet_t sh_d [NUM_BULLETS];
    bullet_t act_q [NUM_BULLETS];

    // Merge this cycle's write into the shadow bank. An index beyond the last slot matches no slot.
    always_comb begin
        for (int k = 0; k < NUM_BULLETS; k++) begin
            sh_d[k] = sh_q[k];
            if (bullet_wr_en_i && bullet_wr_idx_i == 3'(k))
                sh_d[k] = '{x: bullet_wr_x_i, y: bullet_wr_y_i, color: bullet_wr_color_i};
        end
    end

    // Shadow takes writes every cycle. Active takes the merged shadow at frame start,
    // so a same-cycle write is included in that copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BULLETS; k++) begin
                sh_q[k]  <= '0;
                act_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_BULLETS; k++) begin
                sh_q[k] <= sh_d[k];
                if (frame_start_i) act_q[k] <= sh_d[k];
            end
        end
    end

    // ---------------- stage 2: layer priority ----------------
    logic [9:0]         erow, ecol;
    logic               enemy_hit, bhit;
    logic [IDX_W-1:0]   pix_idx;
    logic [COLOR_W-1:0] bcol, backdrop, pix_c, color_q;
    logic               pv_q;

    assign erow      = row_q >> 1;
    assign ecol      = (col_q >> 1) - 10'd2;
    assign enemy_hit = row_q[0] && !col_q[0] && (col_q >= 10'd4) &&
                       (erow < 10'(ENEMY_ROWS)) && (ecol < 10'(ENEMY_COLS));
    assign pix_idx   = IDX_W'(erow * 10'(ENEMY_COLS) + ecol);

`ifdef GRID_LINES_EN
    assign backdrop = line_q ? GRID_C : '0;
`else
    assign backdrop = '0;
`endif

    // Pick the pixel colour. Highest layer first; the lowest-numbered active bullet wins among bullets.
    always_comb begin
        bhit = 1'b0;
        bcol = '0;
        for (int k = 0; k < NUM_BULLETS; k++) begin
            if (!bhit && act_q[k].color != '0 &&
                {6'b0, act_q[k].x} == col_q && {6'b0, act_q[k].y} == row_q) begin
                bhit = 1'b1;
                bcol = act_q[k].color;
            end
        end
        pix_c = backdrop;
        if (!vis_q)                                         pix_c = '0;
        else if (col_q == 10'd0)                            pix_c = HOME_C;
        else if (col_q == 10'd1 && row_q == {6'b0, player_row_i}) pix_c = PLAYER_C;
        else if (bhit)                                      pix_c = bcol;
        else if (enemy_hit)                                 pix_c = cell_q[pix_idx];
    end

    // Register the output colour and the visibility flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= '0;
            pv_q    <= 1'b0;
        end else begin
            color_q <= pix_c;
            pv_q    <= vis_q;
        end
    end

    assign red_o         = color_q[11:8];
    assign green_o       = color_q[7:4];
    assign blue_o        = color_q[3:0];
    assign pixel_valid_o = pv_q;
endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer in its default build (grid lines disabled).
module tb_tile_renderer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  hc, vc;
    logic        fs;
    logic [3:0]  prow;
    logic        ewv, erdy;
    logic [2:0]  erow, ecol;
    logic [11:0] ecolor;
    logic        eclr;
    logic        bwe;
    logic [2:0]  bidx;
    logic [3:0]  bx, by;
    logic [11:0] bcolor;
    logic [3:0]  red, green, blue;
    logic        pvalid;

    int tests = 0;
    int fails = 0;

    tile_renderer dut (
        .clk(clk), .rst_n(rst_n),
        .horiz_count_i(hc), .vert_count_i(vc), .frame_start_i(fs),
        .player_row_i(prow),
        .enemy_wr_valid_i(ewv), .enemy_wr_ready_o(erdy),
        .enemy_wr_row_i(erow), .enemy_wr_col_i(ecol), .enemy_wr_color_i(ecolor),
        .enemy_clear_i(eclr),
        .bullet_wr_en_i(bwe), .bullet_wr_idx_i(bidx), .bullet_wr_x_i(bx),
        .bullet_wr_y_i(by), .bullet_wr_color_i(bcolor),
        .red_o(red), .green_o(green), .blue_o(blue), .pixel_valid_o(pvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [11:0] rgb;
        logic        pv;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one pixel and check the registered colour two cycles later.
    task automatic pix(input string nm, input logic [9:0] h, input logic [9:0] v,
                       input logic [11:0] rgb, input logic pv);
        hc = h;
        vc = v;
        @(posedge clk); @(posedge clk); #1;
        chk({nm, " rgb"}, 32'({red, green, blue}), 32'(rgb));
        chk({nm, " pv"}, 32'(pvalid), 32'(pv));
    endtask

    task automatic enemy_write(input logic [2:0] r, input logic [2:0] c, input logic [11:0] col);
        hc = 10'd700;
        vc = 10'd0;
        @(posedge clk); #1;
        ewv = 1'b1; erow = r; ecol = c; ecolor = col;
        chk("enemy ready in blank", 32'(erdy), 32'd1);
        @(posedge clk); #1;
        ewv = 1'b0;
    endtask

    task automatic bullet_write(input logic [2:0] i, input logic [3:0] x, input logic [3:0] y,
                                input logic [11:0] col, input logic frame);
        bwe = 1'b1; bidx = i; bx = x; by = y; bcolor = col; fs = frame;
        @(posedge clk); #1;
        bwe = 1'b0; fs = 1'b0;
    endtask

    task automatic frame_pulse();
        fs = 1'b1;
        @(posedge clk); #1;
        fs = 1'b0;
    endtask

    initial begin
        vecs[0] = '{h: 10'd0,   v: 10'd0,   rgb: 12'h282, pv: 1'b1};
        vecs[1] = '{h: 10'd39,  v: 10'd479, rgb: 12'h282, pv: 1'b1};
        vecs[2] = '{h: 10'd640, v: 10'd0,   rgb: 12'h000, pv: 1'b0};
        vecs[3] = '{h: 10'd0,   v: 10'd480, rgb: 12'h000, pv: 1'b0};
        vecs[4] = '{h: 10'd40,  v: 10'd160, rgb: 12'hFFF, pv: 1'b1};
        vecs[5] = '{h: 10'd79,  v: 10'd199, rgb: 12'hFFF, pv: 1'b1};
        vecs[6] = '{h: 10'd40,  v: 10'd200, rgb: 12'h000, pv: 1'b1};
        vecs[7] = '{h: 10'd639, v: 10'd479, rgb: 12'h000, pv: 1'b1};
        vecs[8] = '{h: 10'd160, v: 10'd40,  rgb: 12'h000, pv: 1'b1};

        hc = 10'd100; vc = 10'd100; fs = 1'b0; prow = 4'd4;
        ewv = 1'b0; erow = '0; ecol = '0; ecolor = '0; eclr = 1'b0;
        bwe = 1'b0; bidx = '0; bx = '0; by = '0; bcolor = '0;

        // Reset held mid-frame.
        repeat (3) @(posedge clk);
        #1;
        chk("reset rgb", 32'({red, green, blue}), 32'd0);
        chk("reset pv", 32'(pvalid), 32'd0);
        chk("reset ready", 32'(erdy), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            pix($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].rgb, vecs[i].pv);

        // Enemy handshake: stalled during active video, accepted in blanking.
        hc = 10'd100; vc = 10'd100;
        ewv = 1'b1; erow = 3'd2; ecol = 3'd1; ecolor = 12'hF0F;
        @(posedge clk); #1;
        chk("ready in active video", 32'(erdy), 32'd0);
        hc = 10'd700;
        @(posedge clk); #1;
        chk("ready in blank", 32'(erdy), 32'd1);
        @(posedge clk); #1;
        ewv = 1'b0;
        pix("enemy r2c1", 10'd240, 10'd200, 12'hF0F, 1'b1);
        enemy_write(3'd0, 3'd6, 12'h0FF);
        pix("enemy oob col dropped", 10'd160, 10'd120, 12'h000, 1'b1);

        // Bullets: tear-free update and priority.
        bullet_write(3'd0, 4'd5, 4'd3, 12'hF00, 1'b0);
        bullet_write(3'd1, 4'd5, 4'd3, 12'h0F0, 1'b0);
        pix("bullet before frame", 10'd210, 10'd130, 12'h000, 1'b1);
        frame_pulse();
        pix("bullet0 over bullet1", 10'd210, 10'd130, 12'hF00, 1'b1);
        bullet_write(3'd0, 4'd5, 4'd3, 12'h000, 1'b0);
        pix("bullet held mid-frame", 10'd210, 10'd130, 12'hF00, 1'b1);
        bullet_write(3'd1, 4'd5, 4'd3, 12'h00F, 1'b1);
        pix("bullet same-cycle frame", 10'd210, 10'd130, 12'h00F, 1'b1);
        bullet_write(3'd2, 4'd6, 4'd5, 12'h0F0, 1'b0);
        frame_pulse();
        pix("bullet over enemy", 10'd240, 10'd200, 12'h0F0, 1'b1);
        bullet_write(3'd2, 4'd0, 4'd2, 12'h00F, 1'b1);
        pix("home over bullet", 10'd0, 10'd80, 12'h282, 1'b1);
        pix("enemy after bullet moved", 10'd240, 10'd200, 12'hF0F, 1'b1);

        // Clear sequence.
        enemy_write(3'd4, 3'd5, 12'h0F0);
        enemy_write(3'd5, 3'd5, 12'h00F);
        pix("enemy r4c5", 10'd560, 10'd360, 12'h0F0, 1'b1);
        pix("enemy r5c5", 10'd560, 10'd440, 12'h00F, 1'b1);
        hc = 10'd700; vc = 10'd0;
        @(posedge clk); #1;
        ewv = 1'b1; erow = 3'd2; ecol = 3'd3; ecolor = 12'hFFF; eclr = 1'b1;
        #1;
        chk("ready with clear", 32'(erdy), 32'd0);
        @(posedge clk); #1;
        eclr = 1'b0; ewv = 1'b0;
        for (int i = 0; i < 36; i++) begin
            chk($sformatf("ready during clear %0d", i), 32'(erdy), 32'd0);
            eclr = (i == 10);
            @(posedge clk); #1;
        end
        eclr = 1'b0;
        chk("ready after clear", 32'(erdy), 32'd1);
        pix("cleared pending write", 10'd400, 10'd200, 12'h000, 1'b1);
        pix("cleared r2c1", 10'd240, 10'd200, 12'h000, 1'b1);
        pix("cleared r4c5", 10'd560, 10'd360, 12'h000, 1'b1);
        pix("cleared r5c5", 10'd560, 10'd440, 12'h000, 1'b1);

        // Reset in the middle of a clear.
        enemy_write(3'd5, 3'd5, 12'h00F);
        hc = 10'd700;
        eclr = 1'b1;
        @(posedge clk); #1;
        eclr = 1'b0;
        hc = 10'd0; vc = 10'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("home before reset", 32'({red, green, blue}), 32'h282);
        rst_n = 1'b0;
        #1;
        chk("mid-clear reset ready", 32'(erdy), 32'd1);
        chk("mid-clear reset rgb", 32'({red, green, blue}), 32'd0);
        chk("mid-clear reset pv", 32'(pvalid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix("cell zero after reset", 10'd560, 10'd440, 12'h000, 1'b1);
        pix("bullets zero after reset", 10'd210, 10'd130, 12'h000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
